// File: rtl/alu_ex_stage.sv
// Execute stage of the pipelined MIPS core.
// Applies operand forwarding and the immediate mux, runs the ALU, and
// captures the result, flags and pass-through control bits in the EX/MEM
// register. That register supports stall, flush and valid tracking.
//
// Valid semantics: in_valid marks a real instruction in ID/EX. A
// non-stalled edge copies in_valid into out_valid. There is no ready
// signal. Upstream observes stall and holds ID/EX while stall is high.
module alu_ex_stage #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [3:0]            Alu_control,
   input  logic [WIDTH-1:0]      read_data1,
   input  logic [WIDTH-1:0]      read_data2,
   input  logic [WIDTH-1:0]      imm,
   input  logic                  alu_src,
   input  logic [1:0]            fwd_a,
   input  logic [1:0]            fwd_b,
   input  logic [WIDTH-1:0]      wb_data,
   input  logic                  ovf_trap_en,
   input  logic [REG_ADDR_W-1:0] write_reg_in,
   input  logic                  reg_write_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   output logic [WIDTH-1:0]      alu_result,
   output logic [WIDTH-1:0]      store_data,
   output logic                  zero,
   output logic                  overflow,
   output logic [REG_ADDR_W-1:0] write_reg_out,
   output logic                  reg_write_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   output logic                  out_valid
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_XOR = 4'b1101;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] rt_fwd;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] result_c;
   logic             ovf_c;
   logic             trap_c;

   // Forwarding muxes. Select 11 falls back to the ID/EX value.
   // Select 10 uses the register's own output, which is the held value
   // while the stage is stalled.
   always_comb begin
      op_a = read_data1;
      case (fwd_a)
         2'b10:   op_a = alu_result;
         2'b01:   op_a = wb_data;
         default: op_a = read_data1;
      endcase
      rt_fwd = read_data2;
      case (fwd_b)
         2'b10:   rt_fwd = alu_result;
         2'b01:   rt_fwd = wb_data;
         default: rt_fwd = read_data2;
      endcase
      op_b = alu_src ? imm : rt_fwd;
   end

   // The adder and subtractor, with their signed-overflow detection.
   // slt reuses the subtractor's overflow so it stays correct when the
   // difference wraps.
   always_comb begin
      sum     = op_a + op_b;
      diff    = op_a - op_b;
      add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
   end

   // ALU operation select. An undefined code produces 0 and no overflow.
   always_comb begin
      result_c = '0;
      ovf_c    = 1'b0;
      case (Alu_control)
         OP_AND: result_c = op_a & op_b;
         OP_OR:  result_c = op_a | op_b;
         OP_ADD: begin
            result_c = sum;
            ovf_c    = add_ovf;
         end
         OP_SUB: begin
            result_c = diff;
            ovf_c    = sub_ovf;
         end
         OP_SLT: result_c = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         OP_NOR: result_c = ~(op_a | op_b);
         OP_XOR: result_c = op_a ^ op_b;
         default: begin
            result_c = '0;
            ovf_c    = 1'b0;
         end
      endcase
      trap_c = ovf_trap_en & ovf_c;
   end

   // EX/MEM register. Priority is rst, then flush, then stall, then load.
   // A trapped overflow blocks the register and memory writes, but the
   // overflow flag is still recorded.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         alu_result    <= '0;
         store_data    <= '0;
         zero          <= 1'b0;
         overflow      <= 1'b0;
         write_reg_out <= '0;
         reg_write_out <= 1'b0;
         mem_read_out  <= 1'b0;
         mem_write_out <= 1'b0;
         out_valid     <= 1'b0;
      end else if (!stall) begin
         alu_result    <= result_c;
         store_data    <= rt_fwd;
         zero          <= (result_c == '0);
         overflow      <= ovf_c;
         write_reg_out <= write_reg_in;
         reg_write_out <= in_valid & reg_write_in & ~trap_c;
         mem_read_out  <= in_valid & mem_read_in;
         mem_write_out <= in_valid & mem_write_in & ~trap_c;
         out_valid     <= in_valid;
      end
   end

endmodule
